// File: rtl/core_fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Optional same-cycle response bypass is enabled by defining CORE_FETCH_BYPASS_EN.
package core_fetch_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/naive_bus.sv
// Simple request/grant bus; read data returns exactly one cycle after a grant.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    input  rd_gnt, rd_data
  );

  modport slave (
    input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    output rd_gnt, rd_data
  );
endinterface

// File: rtl/core_fetch_fifo.sv
// Synchronous FIFO of fetch entries with single-cycle flush and combinational head.
module core_fetch_fifo
  import core_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output logic [CW-1:0] o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Guards keep the pointers coherent even if a caller misbehaves.
  assign w_do_push = i_push & (r_count != CW'(DEPTH));
  assign w_do_pop  = i_pop & (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push && !rst && !i_flush) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + 1'b1;
      if (w_do_pop)  r_head <= r_head + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/core_instr_fetch_queue.sv
// Pipelined instruction fetch front end: issues bus reads, queues PC-tagged responses.
// Define CORE_FETCH_BYPASS_EN to present a response to decode in its arrival cycle.
module core_instr_fetch_queue
  import core_fetch_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [31:0] BUBBLE_INSTR = RV_NOP,
  localparam int         CW           = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_boot_addr,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  input  logic        i_bus_disable,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  naive_bus.master    bus_master
);

  logic [31:0]  r_fpc;
  logic         r_infl;
  logic [31:0]  r_infl_pc;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_occupancy;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  fetch_entry_t  w_out;
  logic          w_rd_req;
  logic [31:0]   w_rd_addr;
  logic          w_grant;
  logic          w_resp;
  logic          w_empty;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;

  // Reserve a slot for the response already in flight so the queue cannot overflow.
  assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_infl};
  assign w_rd_req    = ~rst & ~i_bus_disable &
                       (i_redirect | (w_occupancy < (CW+1)'(DEPTH)));
  assign w_rd_addr   = i_redirect ? align4(i_redirect_target) : r_fpc;
  assign w_grant     = w_rd_req & bus_master.rd_gnt;

  // A response landing in a redirect cycle belongs to the old path.
  assign w_resp  = r_infl & ~i_redirect;
  assign w_empty = (w_count == '0);

`ifdef CORE_FETCH_BYPASS_EN
  assign w_bypass = w_resp & w_empty & ~rst;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push            = w_resp & ~(w_bypass & i_ready);
  assign w_pop             = ~w_empty & i_ready & ~i_redirect;
  assign w_push_data.pc    = r_infl_pc;
  assign w_push_data.instr = bus_master.rd_data;

  core_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (i_redirect),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // Without a grant the current address is retained, so a redirect target waits here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc     <= align4(i_boot_addr);
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
    end else begin
      r_fpc  <= w_grant ? (w_rd_addr + 32'd4) : w_rd_addr;
      r_infl <= w_grant;
      if (w_grant) r_infl_pc <= w_rd_addr;
    end
  end

  always_comb begin
    w_out = w_head;
    if (w_bypass) begin
      w_out.pc    = r_infl_pc;
      w_out.instr = bus_master.rd_data;
    end
  end

  assign o_valid = ~w_empty | w_bypass;
  assign o_pc    = o_valid ? w_out.pc : 32'h0;
  assign o_instr = o_valid ? w_out.instr : BUBBLE_INSTR;

  assign bus_master.rd_req  = w_rd_req;
  assign bus_master.rd_addr = w_rd_addr;
  assign bus_master.rd_be   = w_rd_req ? 4'hF : 4'h0;
  assign bus_master.wr_req  = 1'b0;
  assign bus_master.wr_be   = 4'h0;
  assign bus_master.wr_addr = 32'h0;
  assign bus_master.wr_data = 32'h0;

endmodule

// File: tb/tb_core_instr_fetch_queue.sv
// Randomised plus directed bench for core_instr_fetch_queue against a queue-based model.
module tb_core_instr_fetch_queue;
  import core_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] boot_addr = 32'h0000_0102;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        bus_disable = 1'b0;
  logic        ready = 1'b0;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;

  naive_bus bus ();

  core_instr_fetch_queue #(
    .DEPTH        (DEPTH),
    .BUBBLE_INSTR (RV_NOP)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_boot_addr       (boot_addr),
    .i_redirect        (redirect),
    .i_redirect_target (redirect_target),
    .i_bus_disable     (bus_disable),
    .i_ready           (ready),
    .o_valid           (o_valid),
    .o_pc              (o_pc),
    .o_instr           (o_instr),
    .bus_master        (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: fetch address, in-flight tag, and the queue itself.
  bit           m_init = 0;
  logic [31:0]  m_fpc = 32'h0;
  bit           m_infl = 0;
  logic [31:0]  m_infl_pc = 32'h0;
  fetch_entry_t m_q[$];

  // Bus slave state, driven from what the DUT actually requested.
  bit           s_infl = 0;
  logic [31:0]  s_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit redir, input logic [31:0] tgt,
                       input bit dis, input bit gnt, input bit rdy);
    bit           e_req, e_valid, resp, byp, grant, byp_taken;
    logic [31:0]  e_addr, e_pc, e_instr;
    fetch_entry_t ent;
    @(negedge clk);
    rst             = r;
    redirect        = redir;
    redirect_target = tgt;
    bus_disable     = dis;
    ready           = rdy;
    bus.rd_gnt      = gnt;
    bus.rd_data     = s_infl ? mem_word(s_addr) : $urandom();
    #1;
    e_req  = !r && !dis && (redir || (m_q.size() + int'(m_infl) < DEPTH));
    e_addr = redir ? align4(tgt) : m_fpc;
    resp   = m_infl && !redir && !r;
    byp    = 0;
`ifdef CORE_FETCH_BYPASS_EN
    byp    = resp && (m_q.size() == 0);
`endif
    e_valid = (m_q.size() > 0) || byp;
    if (m_q.size() > 0) begin
      e_pc = m_q[0].pc;  e_instr = m_q[0].instr;
    end else if (byp) begin
      e_pc = m_infl_pc;  e_instr = mem_word(m_infl_pc);
    end else begin
      e_pc = 32'h0;      e_instr = RV_NOP;
    end
    if (m_init) begin
      chk("rd_req", 32'(bus.rd_req), 32'(e_req));
      if (e_req) begin
        chk("rd_addr", bus.rd_addr, e_addr);
        chk("rd_be", 32'(bus.rd_be), 32'hF);
      end
      chk("wr_req", 32'(bus.wr_req), 32'h0);
      chk("wr_addr", bus.wr_addr | bus.wr_data | 32'(bus.wr_be), 32'h0);
      chk("o_valid", 32'(o_valid), 32'(e_valid));
      chk("o_pc", o_pc, e_pc);
      chk("o_instr", o_instr, e_instr);
    end
    s_infl = bus.rd_req && gnt;
    s_addr = bus.rd_addr;
    grant  = e_req && gnt;
    if (r) begin
      m_q.delete();
      m_infl = 0;
      m_fpc  = align4(boot_addr);
      m_init = 1;
    end else begin
      if (redir) begin
        m_q.delete();
      end else begin
        byp_taken = 0;
        if (e_valid && rdy) begin
          $display("[TB] pop pc=%08h instr=%08h", e_pc, e_instr);
          if (m_q.size() > 0) void'(m_q.pop_front());
          else byp_taken = 1;
        end
        if (resp && !byp_taken) begin
          ent.pc = m_infl_pc;
          ent.instr = mem_word(m_infl_pc);
          m_q.push_back(ent);
        end
      end
      m_fpc  = grant ? e_addr + 32'd4 : e_addr;
      m_infl = grant;
      if (grant) m_infl_pc = e_addr;
    end
  endtask

  int grants;

  initial begin
    bus.rd_gnt  = 1'b0;
    bus.rd_data = 32'h0;

    // Boot and steady-state streaming.
    boot_addr = 32'h0000_0102;
    cycle(1, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("boot_addr", bus.rd_addr, 32'h100);
    chk("boot_valid", 32'(o_valid), 32'h0);
    cycle(0, 0, 0, 0, 1, 1);
    chk("second_addr", bus.rd_addr, 32'h104);
`ifdef CORE_FETCH_BYPASS_EN
    chk("bypass_pc", o_pc, 32'h100);
`else
    chk("lat_valid", 32'(o_valid), 32'h0);
`endif
    cycle(0, 0, 0, 0, 1, 1);
    chk("third_addr", bus.rd_addr, 32'h108);
    chk("first_valid", 32'(o_valid), 32'h1);
`ifdef CORE_FETCH_BYPASS_EN
    chk("first_pc", o_pc, 32'h104);
`else
    chk("first_pc", o_pc, 32'h100);
`endif

    // Backpressure fills the queue: exactly DEPTH grants.
    cycle(1, 0, 0, 0, 1, 0);
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 1, 0);
      if (bus.rd_req) grants++;
    end
    chk("full_grants", 32'(grants), 32'd4);
    chk("full_req", 32'(bus.rd_req), 32'h0);
    chk("full_pc", o_pc, 32'h100);
    cycle(0, 0, 0, 0, 1, 1);
    chk("full_pop_req", 32'(bus.rd_req), 32'h0);
    cycle(0, 0, 0, 0, 1, 0);
    chk("refill_req", 32'(bus.rd_req), 32'h1);
    chk("refill_addr", bus.rd_addr, 32'h110);
    chk("refill_pc", o_pc, 32'h104);

    // Redirect with entries queued and a response in flight.
    cycle(0, 1, 32'h2006, 0, 1, 0);
    chk("redir_addr", bus.rd_addr, 32'h2004);
    cycle(0, 0, 0, 0, 0, 0);
`ifdef CORE_FETCH_BYPASS_EN
    chk("redir_byp_pc", o_pc, 32'h2004);
`else
    chk("redir_flush", 32'(o_valid), 32'h0);
`endif
    cycle(0, 0, 0, 0, 0, 0);
    chk("redir_pc", o_pc, 32'h2004);

    // Grant stall holds the address.
    cycle(0, 1, 32'h300, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 0, 1);
      chk("stall_addr", bus.rd_addr, 32'h300);
    end
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("stall_pc", o_pc, 32'h300);

    // Bus disable after a grant still collects the response.
    cycle(0, 1, 32'h400, 0, 1, 1);
    cycle(0, 0, 0, 1, 1, 0);
    chk("dis_req", 32'(bus.rd_req), 32'h0);
    cycle(0, 0, 0, 1, 1, 0);
    chk("dis_pc", o_pc, 32'h400);
    cycle(0, 0, 0, 0, 0, 0);
    chk("dis_fpc", bus.rd_addr, 32'h404);

    // Reset mid-stream discards queue and in-flight response.
    cycle(0, 1, 32'h500, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 1, 0);
    chk("rst_req", 32'(bus.rd_req), 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_instr", o_instr, 32'h13);
    chk("rst_addr", bus.rd_addr, 32'h100);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) boot_addr = $urandom();
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom(),
            $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core_instr_fetch_queue.md
Name: core_instr_fetch_queue

Overview:
Parametrised instruction-fetch front end for the RV core; the successor to the single-slot instruction-bus adapter.
- Issues pipelined reads on the naive_bus instruction port.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry queue.
- Presents them to decode with a valid/ready handshake.
- Redirects (branch/jump) flush the queue and discard stale bus responses.

Parameters:
- DEPTH, 4: queue entries; power of two, >= 2.
- BUBBLE_INSTR, 32'h0000_0013: value driven on o_instr when o_valid=0 (RV32I NOP).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- i_boot_addr  input  32  first fetch address; bits [1:0] ignored.
- i_redirect  input  1  flush and restart fetch at i_redirect_target.
- i_redirect_target  input  32  redirect address; bits [1:0] forced to 00.
- i_bus_disable  input  1  suppress new bus requests.
- i_ready  input  1  decode accepts the head entry this cycle.
- o_valid  output  1  head entry valid.
- o_pc  output  32  PC of head entry.
- o_instr  output  32  instruction of head entry.
- bus_master  naive_bus.master  -  instruction bus.
  - wr_req=0, wr_be=0, wr_addr=0, wr_data=0 constantly.
  - rd_be=4'hF whenever rd_req=1.

Behaviour:
- Bus protocol: a read is granted when rd_req & rd_gnt in cycle t; rd_data is valid in cycle t+1 only.
- State:
  - fpc[31:0]: next fetch address.
  - infl (1b) / infl_pc[31:0]: a grant occurred last cycle.
  - Queue: count in 0..DEPTH, head/tail pointers wrap modulo DEPTH.
- Request issue:
  - rd_req = ~i_bus_disable & (i_redirect | (count + infl < DEPTH)).
  - rd_addr = i_redirect ? {target[31:2],2'b00} : fpc.
- Grant:
  - fpc <= rd_addr + 4.
  - infl <= 1, infl_pc <= rd_addr.
- No grant:
  - fpc <= rd_addr, so a redirect target is held until granted.
  - infl <= 0.
  - While rd_gnt=0, rd_addr is held stable unless a new redirect occurs.
- Response:
  - If infl=1 and i_redirect=0, enqueue {infl_pc, rd_data}.
  - If i_redirect=1 in that cycle, the response is stale and dropped.
- Dequeue: o_valid & i_ready pops the head. Simultaneous enqueue and dequeue keeps count unchanged; legal at any count.
- Overflow is impossible: the issue rule reserves space for the in-flight response. A full queue with infl=0 holds rd_req=0.
- Redirect takes priority over everything in the same cycle:
  - count <= 0 and pointers reset.
  - A simultaneous dequeue is ignored; the consumer must not rely on a handshake during redirect.
  - o_valid is 0 from the next cycle until new data is enqueued.
- i_bus_disable:
  - Only blocks new requests; an already-granted response is still enqueued.
  - Queue contents remain visible and poppable.
- Outputs:
  - Taken combinationally from the head entry when count>0.
  - Otherwise o_valid=0, o_pc=0, o_instr=BUBBLE_INSTR.
- Reset (sync, rst=1 sampled at clk):
  - fpc <= {i_boot_addr[31:2],2'b00}, count<=0, infl<=0.
  - Outputs go to o_valid=0, o_pc=0, o_instr=BUBBLE_INSTR.
  - Reset mid-operation discards the in-flight response.
  - rd_req=0 while rst=1.
- Latency (no optional feature): grant at t, data at t+1, o_valid at t+2.
- Steady-state throughput: 1 instruction/cycle with rd_gnt=1 and i_ready=1.

Optional Feature:
CORE_FETCH_BYPASS_EN.
- Defined: when count=0 and a non-stale response arrives, o_valid/o_pc/o_instr present it combinationally in the same cycle (t+1).
  - Popped if i_ready=1.
  - Otherwise enqueued as normal.
- Undefined: the response always goes through the queue; o_valid at t+2.

Decomposition:
- Package core_fetch_pkg:
  - typedef struct packed fetch_entry_t {pc[31:0], instr[31:0]}.
  - Constant RV_NOP = 32'h0000_0013.
  - Function align4().
- Sub-module core_fetch_fifo:
  - Synchronous FIFO of fetch_entry_t with flush.
  - Parameter DEPTH.
  - Ports: push, pop, flush, count, head.

Test Plan:
- Reset with i_boot_addr=32'h0000_0102, rd_gnt=1, i_ready=1 -> first rd_addr=0x100; rd_addr then 0x104, 0x108…; o_valid from cycle 3 (cycle 2 with bypass); o_pc 0x100, 0x104…
- i_ready=0, rd_gnt=1, DEPTH=4 -> exactly 4 grants (0x100..0x10C); rd_req then 0; count=4; after i_ready=1 for one cycle, rd_req reasserts with rd_addr=0x110.
- Queue holds 3 entries, infl=1, i_redirect=1 with target 0x2006 -> rd_addr=0x2004 that cycle; old response dropped; next o_valid has o_pc=0x2004.
- rd_gnt=0 for 5 cycles at fpc=0x300 -> rd_addr stays 0x300, no enqueue; first granted cycle then data enqueued with pc 0x300.
- i_bus_disable=1 in the cycle after a grant at 0x400 -> rd_req=0; the 0x400 response is still enqueued; fpc stays 0x404.
- rst=1 asserted for one cycle mid-stream with count=2, infl=1 -> o_valid=0, o_instr=0x13 next cycle; fetch restarts at i_boot_addr; no stale entry appears.
